// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter between two byte producers feeding a
// single 8N1 UART transmitter. Bit timing is taken from the BCLK oversampling
// tick (BAUDCLOCK ticks per bit).
// Optional feature: define UART_TX_PARITY_EN to insert an even parity bit
// between the data bits and the stop bit.
module uart_tx_arbiter #(
    parameter int BAUDCLOCK = 16,
    parameter int DATA_BITS = 8
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 BCLK,
    input  logic                 REQ0,
    input  logic [DATA_BITS-1:0] DATA0,
    output logic                 ACK0,
    input  logic                 REQ1,
    input  logic [DATA_BITS-1:0] DATA1,
    output logic                 ACK1,
    output logic                 TX,
    output logic                 BUSY,
    output logic                 GRANT
);
    localparam int TW = (BAUDCLOCK > 1) ? $clog2(BAUDCLOCK) : 1;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] TLAST = TW'(BAUDCLOCK - 1);
    localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t               state, state_nx;
    logic [TW-1:0]        tcnt, tcnt_nx;
    logic [BW-1:0]        bidx, bidx_nx;
    logic [DATA_BITS-1:0] shreg, shreg_nx;
    logic                 last, last_nx;
    logic                 tx_nx, busy_nx, ack0_nx, ack1_nx, grant_nx;
`ifdef UART_TX_PARITY_EN
    logic                 par, par_nx;
`endif

    logic bit_end;
    logic win0, win1;

    // A bit ends on the final BCLK tick of its BAUDCLOCK-tick window.
    assign bit_end = BCLK && (tcnt == TLAST);

    // Single request wins outright; a tie goes to the producer that did not win last.
    assign win0 = REQ0 && (!REQ1 || last);
    assign win1 = REQ1 && (!REQ0 || !last);

    // Next-state, datapath and registered-output precomputation.
    always_comb begin
        state_nx = state;
        tcnt_nx  = tcnt;
        bidx_nx  = bidx;
        shreg_nx = shreg;
        last_nx  = last;
        grant_nx = GRANT;
        ack0_nx  = 1'b0;
        ack1_nx  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_nx   = par;
`endif

        // Ticks only matter while a frame is in flight; IDLE ignores them.
        if (state != IDLE && BCLK)
            tcnt_nx = bit_end ? '0 : tcnt + TW'(1);

        case (state)
            IDLE: begin
                if (win0) begin
                    shreg_nx = DATA0;
                    ack0_nx  = 1'b1;
                    grant_nx = 1'b0;
                    last_nx  = 1'b0;
                    tcnt_nx  = '0;
                    state_nx = START;
`ifdef UART_TX_PARITY_EN
                    par_nx   = ^DATA0;
`endif
                end else if (win1) begin
                    shreg_nx = DATA1;
                    ack1_nx  = 1'b1;
                    grant_nx = 1'b1;
                    last_nx  = 1'b1;
                    tcnt_nx  = '0;
                    state_nx = START;
`ifdef UART_TX_PARITY_EN
                    par_nx   = ^DATA1;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_nx = DATA;
                    bidx_nx  = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_nx = shreg >> 1;
                    if (bidx == BLAST)
`ifdef UART_TX_PARITY_EN
                        state_nx = PARITY;
`else
                        state_nx = STOP;
`endif
                    else
                        bidx_nx = bidx + BW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) state_nx = STOP;
            end
`endif
            STOP: begin
                if (bit_end) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        // Line level is a function of the state being entered, so TX is registered.
        tx_nx = 1'b1;
        case (state_nx)
            START:   tx_nx = 1'b0;
            DATA:    tx_nx = shreg_nx[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_nx = par_nx;
`endif
            default: tx_nx = 1'b1;
        endcase
        busy_nx = (state_nx != IDLE);
    end

    // State and output registers; reset drops any partial frame.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            tcnt  <= '0;
            bidx  <= '0;
            shreg <= '0;
            last  <= 1'b1;
            TX    <= 1'b1;
            BUSY  <= 1'b0;
            ACK0  <= 1'b0;
            ACK1  <= 1'b0;
            GRANT <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            tcnt  <= tcnt_nx;
            bidx  <= bidx_nx;
            shreg <= shreg_nx;
            last  <= last_nx;
            TX    <= tx_nx;
            BUSY  <= busy_nx;
            ACK0  <= ack0_nx;
            ACK1  <= ack1_nx;
            GRANT <= grant_nx;
`ifdef UART_TX_PARITY_EN
            par   <= par_nx;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed table of transactions, hand-written
// streaming/reset sequences, and randomized producers checked every cycle
// against a frame-level reference model (bit list indexed by elapsed ticks).
module tb_uart_tx_arbiter;
    localparam int BC = 16;
    localparam int DB = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NB = DB + 3;
`else
    localparam int NB = DB + 2;
`endif

    logic          CLK = 1'b0, RST_N = 1'b0, BCLK = 1'b0;
    logic          REQ0 = 1'b0, REQ1 = 1'b0;
    logic [DB-1:0] DATA0 = '0, DATA1 = '0;
    logic          ACK0, ACK1, TX, BUSY, GRANT;

    uart_tx_arbiter #(.BAUDCLOCK(BC), .DATA_BITS(DB)) dut (
        .CLK(CLK), .RST_N(RST_N), .BCLK(BCLK),
        .REQ0(REQ0), .DATA0(DATA0), .ACK0(ACK0),
        .REQ1(REQ1), .DATA1(DATA1), .ACK1(ACK1),
        .TX(TX), .BUSY(BUSY), .GRANT(GRANT)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0, n_err = 0;
    int bper = 1, bcnt = 0, tick_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // BCLK: every bper cycles, or random when bper==0.
    always @(posedge CLK) begin
        #2;
        bcnt++;
        if (bper == 0) BCLK = ($urandom_range(0, 1) == 1);
        else           BCLK = ((bcnt % bper) == 0);
    end

    // Reference model: a frame is a list of NB line levels; the level on the
    // line is the entry at (ticks since capture) / BC.
    bit m_busy = 1'b0, m_last = 1'b1, m_grant = 1'b0, m_ack0 = 1'b0, m_ack1 = 1'b0;
    int m_ticks = 0, m_w = 0;
    bit m_bits[NB];

    function automatic bit exp_tx();
        return m_busy ? m_bits[m_ticks / BC] : 1'b1;
    endfunction

    always @(posedge CLK) begin
        logic [DB-1:0] byt;
        if (BCLK) tick_total++;
        if (!RST_N) begin
            m_busy = 1'b0; m_last = 1'b1; m_grant = 1'b0; m_ack0 = 1'b0; m_ack1 = 1'b0;
        end else begin
            m_ack0 = 1'b0; m_ack1 = 1'b0;
            if (!m_busy) begin
                m_w = -1;
                if (REQ0 && REQ1) m_w = m_last ? 0 : 1;
                else if (REQ0)    m_w = 0;
                else if (REQ1)    m_w = 1;
                if (m_w >= 0) begin
                    byt = (m_w == 1) ? DATA1 : DATA0;
                    m_bits[0] = 1'b0;
                    for (int i = 0; i < DB; i++) m_bits[1 + i] = byt[i];
`ifdef UART_TX_PARITY_EN
                    m_bits[DB + 1] = ^byt;
`endif
                    m_bits[NB - 1] = 1'b1;
                    m_busy = 1'b1; m_ticks = 0;
                    m_grant = (m_w == 1); m_last = (m_w == 1);
                    m_ack0 = (m_w == 0); m_ack1 = (m_w == 1);
                end
            end else begin
                if (BCLK) m_ticks++;
                if (m_ticks == NB * BC) m_busy = 1'b0;
            end
        end
        #1;
        chk("model_outputs", 32'({TX, BUSY, ACK0, ACK1, GRANT}),
            32'({exp_tx(), m_busy, m_ack0, m_ack1, m_grant}));
    end

    task automatic wait_ack(output int lat, output int who, output int base);
        lat = 0; who = -1; base = 0;
        for (int i = 0; i < 40 && who < 0; i++) begin
            @(posedge CLK); #3; lat++;
            if (ACK0 || ACK1) begin
                who  = ACK1 ? 1 : 0;
                base = tick_total;
            end
        end
        if (who < 0) begin
            n_vec++; n_err++;
            $display("FAIL ack_wait: no ACK within 40 cycles at %0t", $time);
        end
    endtask

    // Samples the line in the middle of each bit, counted in BCLK ticks since capture.
    task automatic decode(input int base, output logic [DB-1:0] byt, output bit fmt);
        bit bits[NB];
        int b = 0, guard = 0;
        while (b < NB && guard < 4000) begin
            if (tick_total - base == b * BC + BC / 2) begin
                bits[b] = TX; b++;
            end else begin
                @(posedge CLK); #3; guard++;
            end
        end
        if (b < NB) begin
            n_vec++; n_err++;
            $display("FAIL decode: frame incomplete, %0d of %0d bits", b, NB);
        end
        for (int i = 0; i < DB; i++) byt[i] = bits[1 + i];
        fmt = (bits[0] == 1'b0) && (bits[NB - 1] == 1'b1);
`ifdef UART_TX_PARITY_EN
        fmt = fmt && (bits[DB + 1] == ^byt);
`endif
    endtask

    task automatic wait_idle(input int base);
        int g = 0;
        while (BUSY && g < 4000) begin @(posedge CLK); #3; g++; end
        if (BUSY) begin
            n_vec++; n_err++;
            $display("FAIL idle_wait: BUSY still high after 4000 cycles");
        end else begin
            chk("frame_ticks", 32'(tick_total - base), 32'(NB * BC));
        end
    endtask

    // Starts a frame for producer p, resets during data bit 3, then checks a tie goes to 0.
    task automatic reset_mid(input int p);
        int lat, who, base, g;
        logic [DB-1:0] byt;
        bit fmt;
        bper = 1;
        if (p == 1) begin REQ1 = 1'b1; DATA1 = 8'h96; end
        else        begin REQ0 = 1'b1; DATA0 = 8'h96; end
        wait_ack(lat, who, base);
        chk($sformatf("rst%0d_grant_before", p), 32'(GRANT), 32'(p));
        @(posedge CLK); #3;
        REQ0 = 1'b0; REQ1 = 1'b0;
        g = 0;
        while (tick_total - base < 4 * BC + 6 && g < 400) begin @(posedge CLK); #3; g++; end
        chk($sformatf("rst%0d_busy_mid", p), 32'({BUSY, TX}), 32'({1'b1, 1'b0}));
        RST_N = 1'b0;
        #1;
        chk($sformatf("rst%0d_async", p), 32'({TX, BUSY, GRANT, ACK0, ACK1}), 32'(5'b10000));
        repeat (2) @(posedge CLK);
        #2; RST_N = 1'b1; #1;
        REQ0 = 1'b1; REQ1 = 1'b1; DATA0 = 8'h11; DATA1 = 8'h22;
        wait_ack(lat, who, base);
        chk($sformatf("rst%0d_tie_winner", p), 32'(who), 32'd0);
        chk($sformatf("rst%0d_tie_grant", p), 32'(GRANT), 32'd0);
        @(posedge CLK); #3;
        REQ0 = 1'b0; REQ1 = 1'b0;
        decode(base, byt, fmt);
        chk($sformatf("rst%0d_tie_byte", p), 32'(byt), 32'h11);
        wait_idle(base);
        @(posedge CLK); #3;
    endtask

    typedef struct {
        int            bper;
        bit            r0, r1;
        logic [DB-1:0] d0, d1;
        bit            eg;
        logic [DB-1:0] eb;
    } vec_t;

    vec_t tbl[11];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, who, base;
        int ew[6];
        logic [DB-1:0] byt, eb;
        bit fmt, pend0, pend1, act0, act1;

        tbl[0]  = '{4, 1'b1, 1'b0, 8'hA5, 8'h00, 1'b0, 8'hA5};
        tbl[1]  = '{1, 1'b0, 1'b1, 8'h00, 8'h3C, 1'b1, 8'h3C};
        tbl[2]  = '{1, 1'b1, 1'b1, 8'h11, 8'h22, 1'b0, 8'h11};
        tbl[3]  = '{1, 1'b1, 1'b1, 8'h11, 8'h22, 1'b1, 8'h22};
        tbl[4]  = '{1, 1'b1, 1'b1, 8'h11, 8'h22, 1'b0, 8'h11};
        tbl[5]  = '{1, 1'b1, 1'b1, 8'h11, 8'h22, 1'b1, 8'h22};
        tbl[6]  = '{0, 1'b0, 1'b1, 8'h00, 8'h80, 1'b1, 8'h80};
        tbl[7]  = '{0, 1'b1, 1'b1, 8'h01, 8'hFE, 1'b0, 8'h01};
        tbl[8]  = '{1, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 8'hFF};
        tbl[9]  = '{1, 1'b1, 1'b1, 8'h00, 8'h5A, 1'b1, 8'h5A};
        tbl[10] = '{1, 1'b1, 1'b0, 8'h07, 8'h00, 1'b0, 8'h07};

        // Reset state
        repeat (3) @(posedge CLK);
        #3;
        chk("reset_state", 32'({TX, BUSY, GRANT, ACK0, ACK1}), 32'(5'b10000));
        @(posedge CLK); #2; RST_N = 1'b1;
        repeat (3) @(posedge CLK);
        #3;
        chk("idle_ignores_ticks", 32'({TX, BUSY}), 32'(2'b10));

        // Table of single transactions
        for (int i = 0; i < 11; i++) begin
            bper = tbl[i].bper;
            REQ0 = tbl[i].r0; REQ1 = tbl[i].r1;
            DATA0 = tbl[i].d0; DATA1 = tbl[i].d1;
            wait_ack(lat, who, base);
            chk($sformatf("tbl%0d_ack_latency", i), 32'(lat), 32'd1);
            chk($sformatf("tbl%0d_ack", i), 32'({ACK1, ACK0}), tbl[i].eg ? 32'd2 : 32'd1);
            chk($sformatf("tbl%0d_grant", i), 32'(GRANT), 32'(tbl[i].eg));
            chk($sformatf("tbl%0d_start", i), 32'({TX, BUSY}), 32'(2'b01));
            @(posedge CLK); #3;
            chk($sformatf("tbl%0d_ack_drop", i), 32'({ACK1, ACK0}), 32'd0);
            REQ0 = 1'b0; REQ1 = 1'b0;
            decode(base, byt, fmt);
            chk($sformatf("tbl%0d_byte", i), 32'(byt), 32'(tbl[i].eb));
            chk($sformatf("tbl%0d_framing", i), 32'(fmt), 32'd1);
            wait_idle(base);
            @(posedge CLK); #3;
        end

        // Producer 1 streams; producer 0 arrives late and then both stay high
        ew = '{1, 1, 1, 0, 1, 0};
        bper = 1;
        REQ1 = 1'b1; DATA1 = 8'hC0;
        for (int f = 0; f < 6; f++) begin
            wait_ack(lat, who, base);
            chk($sformatf("stream%0d_gap", f), 32'(lat), 32'd1);
            chk($sformatf("stream%0d_winner", f), 32'(who), 32'(ew[f]));
            eb = (ew[f] == 1) ? DATA1 : DATA0;
            @(posedge CLK); #3;
            if (ew[f] == 1) DATA1 = DATA1 + 8'h01;
            if (f == 5) begin REQ0 = 1'b0; REQ1 = 1'b0; end
            decode(base, byt, fmt);
            chk($sformatf("stream%0d_byte", f), 32'(byt), 32'(eb));
            if (f == 2) begin REQ0 = 1'b1; DATA0 = 8'h77; end
            wait_idle(base);
        end
        @(posedge CLK); #3;

        // Reset in the middle of a data bit
        reset_mid(1);
        reset_mid(0);

        // Randomized producers, checked cycle by cycle against the model
        pend0 = 1'b0; pend1 = 1'b0;
        bper = 0;
        for (int c = 0; c < 5000; c++) begin
            @(posedge CLK); #2;
            if (c == 2500) bper = 1;
            act0 = pend0; pend0 = m_ack0;
            act1 = pend1; pend1 = m_ack1;
            if (REQ0) begin
                if (act0) begin
                    if ($urandom_range(0, 1) == 1) REQ0 = 1'b0;
                    else DATA0 = DB'($urandom);
                end else if (!pend0 && $urandom_range(0, 99) < 2) REQ0 = 1'b0;
            end else if ($urandom_range(0, 99) < 4) begin
                REQ0 = 1'b1; DATA0 = DB'($urandom);
            end
            if (REQ1) begin
                if (act1) begin
                    if ($urandom_range(0, 1) == 1) REQ1 = 1'b0;
                    else DATA1 = DB'($urandom);
                end else if (!pend1 && $urandom_range(0, 99) < 2) REQ1 = 1'b0;
            end else if ($urandom_range(0, 99) < 4) begin
                REQ1 = 1'b1; DATA1 = DB'($urandom);
            end
        end
        REQ0 = 1'b0; REQ1 = 1'b0;
        for (int g = 0; g < 2000 && BUSY; g++) begin @(posedge CLK); #3; end
        repeat (3) @(posedge CLK);
        #3;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
